am_modulator_upconverter: RTL and testbench

//  Transmit-side counterpart of the 8 kHz demodulation lowpass path.
//  - Accepts Q1.31 baseband samples over a valid/ready handshake and buffers them in a 2-entry FIFO.
//  - Zero-order-hold interpolates each sample by INTERP_FACTOR output strobes.
//  - Mixes the held sample with an NCO carrier and drives a 64-bit Q2.62 product.
//  - The output feeds the demodulator's 64-bit filter input in loopback and in the transmit chain.

---
 rtl/am_modulator_upconverter.sv | 125 ++++++++++++
 tb/tb_am_modulator_upconverter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/am_modulator_upconverter.sv
// AM upconverter: 2-deep sample FIFO, zero-order-hold interpolation, NCO quarter-wave carrier mixer.
// Latency: 1 clk from an enabled cycle to ce_out/mod_output. Optional full-carrier mode: MOD_CARRIER_INSERT_EN.
// Backpressure: in_ready drops when the FIFO holds 2 samples; an empty FIFO at a sample slot pulses underrun.
module am_modulator_upconverter #(
    parameter int                     PHASE_WIDTH   = 32,
    parameter logic [PHASE_WIDTH-1:0] PHASE_INC     = 32'h04000000,
    parameter int                     INTERP_FACTOR = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_enable,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        ce_out,
    output logic [63:0] mod_output,
    output logic        underrun,
    output logic [1:0]  fifo_level
);

    localparam int            CW       = (INTERP_FACTOR > 1) ? $clog2(INTERP_FACTOR) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(INTERP_FACTOR - 1);

    logic [31:0]            fifo_mem [2];
    logic                   wr_ptr;
    logic                   rd_ptr;
    logic [1:0]             level;
    logic [PHASE_WIDTH-1:0] phase;
    logic [CW-1:0]          interp_cnt;
    logic signed [31:0]     held;

    logic                   sample_due;
    logic                   push;
    logic                   pop;
    logic signed [31:0]     sel;
    logic signed [31:0]     mix;
    logic [1:0]             quad;
    logic [3:0]             lut_addr;
    logic signed [31:0]     lut_val;
    logic signed [31:0]     carrier;
    logic signed [63:0]     product;

    assign in_ready   = (level != 2'd2);
    assign fifo_level = level;
    assign sample_due = clk_enable && (interp_cnt == '0);
    assign push       = in_valid && in_ready;
    assign pop        = sample_due && (level != 2'd0);

    // A pop this cycle feeds the mixer directly so the new sample is not delayed a slot.
    assign sel = pop ? signed'(fifo_mem[rd_ptr]) : held;

`ifdef MOD_CARRIER_INSERT_EN
    assign mix = (sel >>> 1) + 32'sh40000000;
`else
    assign mix = sel;
`endif

    assign quad     = phase[PHASE_WIDTH-1 -: 2];
    assign lut_addr = quad[0] ? ~phase[PHASE_WIDTH-3 -: 4] : phase[PHASE_WIDTH-3 -: 4];

    always_comb begin
        lut_val = 32'sd0;
        case (lut_addr)
            4'd0:  lut_val = 32'sd105372028;
            4'd1:  lut_val = 32'sd315101294;
            4'd2:  lut_val = 32'sd521795963;
            4'd3:  lut_val = 32'sd723465451;
            4'd4:  lut_val = 32'sd918167571;
            4'd5:  lut_val = 32'sd1104027236;
            4'd6:  lut_val = 32'sd1279254515;
            4'd7:  lut_val = 32'sd1442161874;
            4'd8:  lut_val = 32'sd1591180425;
            4'd9:  lut_val = 32'sd1724875039;
            4'd10: lut_val = 32'sd1841958164;
            4'd11: lut_val = 32'sd1941302224;
            4'd12: lut_val = 32'sd2021950483;
            4'd13: lut_val = 32'sd2083126253;
            4'd14: lut_val = 32'sd2124240379;
            4'd15: lut_val = 32'sd2144896909;
            default: lut_val = 32'sd0;
        endcase
    end

    // Table entries are below 2^31, so negation never produces -2^31.
    assign carrier = quad[1] ? -lut_val : lut_val;
    assign product = {{32{mix[31]}}, mix} * {{32{carrier[31]}}, carrier};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            level       <= 2'd0;
            phase       <= '0;
            interp_cnt  <= '0;
            held        <= '0;
            ce_out      <= 1'b0;
            underrun    <= 1'b0;
            mod_output  <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= in_data;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
                held   <= sel;
            end
            case ({push, pop})
                2'b10:   level <= level + 2'd1;
                2'b01:   level <= level - 2'd1;
                default: level <= level;
            endcase
            ce_out   <= clk_enable;
            underrun <= sample_due && (level == 2'd0);
            if (clk_enable) begin
                mod_output <= product;
                phase      <= phase + PHASE_INC;
                interp_cnt <= (interp_cnt == CNT_LAST) ? '0 : interp_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_am_modulator_upconverter.sv
// Directed bench for am_modulator_upconverter; expected products come from a real-valued sine model.
module tb_am_modulator_upconverter;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_enable;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        ce_out;
    logic [63:0] mod_output;
    logic        underrun;
    logic [1:0]  fifo_level;

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    logic [63:0] outs [64];
    logic [63:0] last_out;

    always #5 clk = ~clk;

    am_modulator_upconverter dut (
        .clk        (clk),
        .reset      (reset),
        .clk_enable (clk_enable),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ce_out     (ce_out),
        .mod_output (mod_output),
        .underrun   (underrun),
        .fifo_level (fifo_level)
    );

    function automatic longint lut_m(input int k);
        real x;
        x = 2147483647.0 * $sin(3.141592653589793 * (real'(k) + 0.5) / 32.0);
        return longint'($floor(x + 0.5));
    endfunction

    function automatic longint carrier_m(input int p);
        int q;
        int i;
        longint v;
        q = (p / 16) % 4;
        i = p % 16;
        v = (q % 2 == 1) ? lut_m(15 - i) : lut_m(i);
        return (q >= 2) ? -v : v;
    endfunction

    function automatic logic [63:0] exp_out(input logic [31:0] h, input int p);
        longint hv;
        longint s;
        hv = longint'(signed'(h));
`ifdef MOD_CARRIER_INSERT_EN
        s = (hv >>> 1) + 64'sh40000000;
`else
        s = hv;
`endif
        return 64'(s * carrier_m(p));
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_out"}, mod_output, 64'd0);
        chk1({tag, "_ce"}, ce_out, 1'b0);
        chk1({tag, "_underrun"}, underrun, 1'b0);
        chk1({tag, "_ready"}, in_ready, 1'b1);
        chk({tag, "_level"}, 64'(fifo_level), 64'd0);
    endtask

    initial begin
        reset      = 1'b0;
        clk_enable = 1'b1;
        in_valid   = 1'b1;
        in_data    = 32'h11111111;
        repeat (3) step();
        chk_reset_vals("reset");

        // Release reset; the pending push lands on the first edge.
        clk_enable = 1'b0;
        in_data    = 32'h40000000;
        reset      = 1'b1;
        step();
        chk("first_push_level", 64'(fifo_level), 64'd1);
        in_valid   = 1'b0;

        // One sample, then continuous enables: underrun only at the 9th.
        clk_enable = 1'b1;
        for (int k = 0; k < 16; k++) begin
            step();
            chk1($sformatf("ce_%0d", k), ce_out, 1'b1);
            chk($sformatf("zoh_out_%0d", k), mod_output, exp_out(32'h40000000, k));
            chk1($sformatf("underrun_%0d", k), underrun, k == 8);
        end
        clk_enable = 1'b0;
        step();
        chk1("idle_ce", ce_out, 1'b0);
        chk1("idle_underrun", underrun, 1'b0);
        chk("idle_hold", mod_output, exp_out(32'h40000000, 15));

        // Fill the FIFO, stall, pop once, then the stalled push enters.
        in_valid = 1'b1;
        in_data  = 32'h7FFFFFFF;
        step();
        chk("fill1_level", 64'(fifo_level), 64'd1);
        chk1("fill1_ready", in_ready, 1'b1);
        in_data = 32'h12345678;
        step();
        chk("fill2_level", 64'(fifo_level), 64'd2);
        chk1("fill2_ready", in_ready, 1'b0);
        in_data = 32'h0ABCDEF0;
        step();
        chk("stall_level", 64'(fifo_level), 64'd2);
        clk_enable = 1'b1;
        step();
        chk("pop_level", 64'(fifo_level), 64'd1);
        chk1("pop_ready", in_ready, 1'b1);
        chk("pop_out", mod_output, exp_out(32'h7FFFFFFF, 16));
        clk_enable = 1'b0;
        step();
        chk("late_push_level", 64'(fifo_level), 64'd2);
        in_valid = 1'b0;

        // Full FIFO mid-hold: asynchronous reset clears outputs at once.
        reset = 1'b0;
        #1;
        chk_reset_vals("midreset");
        step();
        reset = 1'b1;

        // Full-scale sample for one carrier period starting from phase 0.
        in_valid = 1'b1;
        in_data  = 32'h7FFFFFFF;
        step();
        step();
        clk_enable = 1'b1;
        for (int k = 0; k < 64; k++) begin
            step();
            outs[k] = mod_output;
            chk($sformatf("period_out_%0d", k), mod_output, exp_out(32'h7FFFFFFF, k));
            chk1($sformatf("period_underrun_%0d", k), underrun, 1'b0);
        end
        for (int k = 0; k < 32; k++)
            chk($sformatf("sym_neg_%0d", k), outs[k + 32], -outs[k]);
        for (int j = 0; j < 16; j++)
            chk($sformatf("sym_mirror_%0d", j), outs[16 + j], outs[15 - j]);

        // Enable pattern 1,0,0,1 after one idle cycle.
        in_valid   = 1'b0;
        clk_enable = 1'b0;
        step();
        chk1("gap_ce_0", ce_out, 1'b0);
        chk("gap_out_0", mod_output, outs[63]);
        clk_enable = 1'b1;
        step();
        chk1("gap_ce_1", ce_out, 1'b1);
        chk("gap_out_1", mod_output, exp_out(32'h7FFFFFFF, 0));
        last_out   = mod_output;
        clk_enable = 1'b0;
        step();
        chk1("gap_ce_2", ce_out, 1'b0);
        chk("gap_out_2", mod_output, last_out);
        step();
        chk1("gap_ce_3", ce_out, 1'b0);
        chk("gap_out_3", mod_output, last_out);
        clk_enable = 1'b1;
        step();
        chk1("gap_ce_4", ce_out, 1'b1);
        chk("gap_out_4", mod_output, exp_out(32'h7FFFFFFF, 1));
        step();
        chk("gap_out_5", mod_output, exp_out(32'h7FFFFFFF, 2));

        // Most negative sample (zero envelope in full-carrier mode).
        clk_enable = 1'b0;
        reset      = 1'b0;
        step();
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'h80000000;
        step();
        in_valid   = 1'b0;
        clk_enable = 1'b1;
        for (int k = 0; k < 16; k++) begin
            step();
            chk($sformatf("neg_out_%0d", k), mod_output, exp_out(32'h80000000, k));
            chk1($sformatf("neg_underrun_%0d", k), underrun, k == 8);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
